// File: rtl/uart_pkg.sv
// Shared UART definitions, used by the transmitter and by the receiver-side checker.
//   tx_state_e     : transmitter FSM states
//   UART_IDLE_LVL  : line level between frames and during stop bits
//   UART_START_LVL : line level of the start bit
//   uart_parity()  : parity bit for a data byte (even or odd)
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;

  // Even parity makes the total number of ones (data + parity) even.
  function automatic logic uart_parity(input logic [7:0] data, input logic odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO for the UART transmitter.
//   i_clk, i_rst : clock, asynchronous active-high reset (flushes the FIFO)
//   i_push/i_data: write request and byte; ignored while full
//   i_pop        : read request; ignored while empty
//   o_data       : registered head-of-queue byte, valid whenever !o_empty
//   o_full, o_empty, o_level : status from the registered occupancy counter
module uart_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [7:0]               i_data,
  input  logic                     i_pop,
  output logic [7:0]               o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          do_push, do_pop;

  assign o_full  = (count_q == (AW+1)'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_level = count_q;
  assign o_data  = rd_data_q;

  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    // The output register tracks the slot the read pointer will point at.
    // If that slot is being written this very cycle (queue empty, or about
    // to become empty), forward the incoming byte so a single-entry queue
    // presents its head one cycle after the push.
    if (do_push && (wr_ptr_q == rd_ptr_d)) rd_data_d = i_data;
    else                                   rd_data_d = mem[rd_ptr_d];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage and read register carry no reset so they map onto RAM primitives.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr_q] <= i_data;
    rd_data_q <= rd_data_d;
  end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: valid/ready byte input, FIFO buffering, 8-bit LSB-first
// frames with optional parity and one or two stop bits.
//   i_clk, i_rst  : clock, asynchronous active-high reset (aborts any frame)
//   i_data/i_valid/o_ready : byte input handshake, o_ready = FIFO not full
//   o_uart_tx     : registered serial line, idle high
//   o_busy        : a frame is in progress or bytes are queued
//   o_fifo_level  : FIFO occupancy
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [7:0]                    i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic                          o_uart_tx,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

  localparam int                BAUD_W      = $clog2(CLK_DIV);
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLK_DIV - 1);
  localparam logic [2:0]        LAST_STOP   = 3'(STOP_BITS - 1);

  tx_state_e   state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  data_q, data_d;
  logic        tx_q, tx_d;

  logic        fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_data;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  logic        baud_done, launch;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_valid),
    .i_data  (i_data),
    .i_pop   (fifo_pop),
    .o_data  (fifo_data),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_level (fifo_level)
  );

  assign o_ready      = !fifo_full;
  assign o_fifo_level = fifo_level;
  assign o_busy       = (state_q != ST_IDLE) || (fifo_level != '0);
  assign o_uart_tx    = tx_q;
  assign baud_done    = (baud_q == '0);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    data_d   = data_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
    // launch: try to start the next frame (from idle, or straight after the
    // last stop bit so consecutive frames have no idle gap).
    launch   = 1'b0;

    case (state_q)
      ST_IDLE: launch = 1'b1;
      ST_START: begin
        if (baud_done) begin
          state_d = ST_DATA;
          baud_d  = BAUD_RELOAD;
          bit_d   = 3'd0;
          tx_d    = data_q[0];
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          baud_d = BAUD_RELOAD;
          if (bit_q == 3'd7) begin
            if (PARITY_EN != 0) begin
              state_d = ST_PARITY;
              tx_d    = uart_parity(data_q, PARITY_ODD != 0);
            end else begin
              state_d = ST_STOP;
              bit_d   = 3'd0;
              tx_d    = UART_IDLE_LVL;
            end
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = data_q[bit_q + 3'd1];
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      ST_PARITY: begin
        if (baud_done) begin
          state_d = ST_STOP;
          baud_d  = BAUD_RELOAD;
          bit_d   = 3'd0;
          tx_d    = UART_IDLE_LVL;
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_done) begin
          // Each stop bit is timed separately so every bit is CLK_DIV cycles.
          if (bit_q == LAST_STOP) begin
            launch = 1'b1;
          end else begin
            bit_d  = bit_q + 3'd1;
            baud_d = BAUD_RELOAD;
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (launch) begin
      if (!fifo_empty) begin
        fifo_pop = 1'b1;
        data_d   = fifo_data;
        state_d  = ST_START;
        baud_d   = BAUD_RELOAD;
        tx_d     = UART_START_LVL;
      end else begin
        state_d = ST_IDLE;
        tx_d    = UART_IDLE_LVL;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      tx_q    <= UART_IDLE_LVL;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
    end
  end

endmodule
